// File: rtl/seg7_scan2.sv
// seg7_scan2: two-digit multiplexed 7-segment driver for a 0..15 count with wrap indicator.
module seg7_scan2 #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GAP_CYC  = 500
) (
  input  logic       f_crystal,
  input  logic       rst_n,
  input  logic [3:0] q,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       dp_n
);
  typedef enum logic [1:0] {S_ONES, S_GAP0, S_TENS, S_GAP1} state_t;
  localparam logic [19:0] ONES_LAST = 20'(SCAN_DIV - 1);
  localparam logic [19:0] GAP_LAST  = 20'(GAP_CYC - 1);
  state_t      state;
  logic [19:0] phase;
  logic [3:0]  q_hold;
  logic        wrap;
  logic        fresh;
  logic        last;
  logic        tens;
  logic [3:0]  ones;
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: seg_code = 7'b1000000;
      4'd1: seg_code = 7'b1111001;
      4'd2: seg_code = 7'b0100100;
      4'd3: seg_code = 7'b0110000;
      4'd4: seg_code = 7'b0011001;
      4'd5: seg_code = 7'b0010010;
      4'd6: seg_code = 7'b0000010;
      4'd7: seg_code = 7'b1111000;
      4'd8: seg_code = 7'b0000000;
      4'd9: seg_code = 7'b0010000;
      default: seg_code = 7'h7F;
    endcase
  endfunction
  always_comb begin
    last = phase == ((state == S_ONES || state == S_TENS) ? ONES_LAST : GAP_LAST);
    tens = q_hold >= 4'd10;
    ones = tens ? q_hold - 4'd10 : q_hold;
  end
  // fresh marks the first cycle out of reset, which counts as a new S_ONES entry with outputs still dark
  always_ff @(posedge f_crystal) begin
    if (!rst_n) begin
      state  <= S_ONES;
      phase  <= '0;
      q_hold <= '0;
      wrap   <= 1'b0;
      fresh  <= 1'b1;
      an     <= 2'b11;
      seg    <= 7'h7F;
      dp_n   <= 1'b1;
    end else begin
      fresh <= 1'b0;
      if (fresh || (last && state == S_GAP1)) begin
        state  <= S_ONES;
        phase  <= '0;
        q_hold <= q;
        wrap   <= (q_hold == 4'd15 && q == 4'd0) ? 1'b1 : (q != 4'd0 ? 1'b0 : wrap);
      end else if (last) begin
        state <= state_t'(state + 2'd1);
        phase <= '0;
      end else begin
        phase <= phase + 20'd1;
      end
      an   <= fresh ? 2'b11 : state == S_ONES ? 2'b10 : (state == S_TENS && tens) ? 2'b01 : 2'b11;
      seg  <= fresh ? 7'h7F : state == S_ONES ? seg_code(ones) : (state == S_TENS && tens) ? seg_code(4'd1) : 7'h7F;
      dp_n <= !(state == S_ONES && wrap && !fresh);
    end
  end
endmodule
